rvfi_obi_mem_model: RTL and testbench
=====================================

Name: rvfi_obi_mem_model

Overview:
Protocol-constrained memory responder for the formal harness around the core's OBI instruction and data ports; one instance per port. The solver supplies free grant/valid/data choices. This block turns them into OBI-legal gnt/rvalid/rdata back to the core:
- no grant without a request;
- in-order responses, never early;
- bounded outstanding transactions;
- bounded stalls (fairness).
It also flags core-side OBI stability violations.

Parameters:
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (1..4)
MAX_STALL, 4, max consecutive cycles a pending request or pending response may be withheld; 0 disables the fairness bound
DATA_W, 32, data/rdata width (32 for data port, INSTR_RDATA_WIDTH for instr port)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
req_i  in  1  core request
addr_i  in  32  core address
we_i  in  1  core write enable (tie 0 on instr port)
be_i  in  4  core byte enables (tie 4'hF on instr port)
wdata_i  in  DATA_W  core write data
rand_gnt_i  in  1  solver-chosen grant wish
rand_rvalid_i  in  1  solver-chosen response wish
rand_rdata_i  in  DATA_W  solver-chosen read data
gnt_o  out  1  grant to core
rvalid_o  out  1  response valid to core
rdata_o  out  DATA_W  response data to core
outstanding_o  out  3  current outstanding count
proto_err_o  out  1  sticky core-side OBI violation

Behaviour:
- Reset is asynchronous and active-high. While it is asserted:
  - gnt_o, rvalid_o and proto_err_o = 0; rdata_o = 0; outstanding_o = 0;
  - the FIFO, stall counters and request snapshot are cleared.
- Reset mid-transaction discards all outstanding entries. No response is ever issued for pre-reset grants.
- Grant (combinational):
  - gnt_o = req_i && slot_free && (rand_gnt_i || gnt_stall == MAX_STALL), where slot_free = (count < MAX_OUTSTANDING) || rvalid_o.
  - gnt_o is never 1 when req_i = 0.
- Response (combinational):
  - rvalid_o = (count > 0) && (rand_rvalid_i || rsp_stall == MAX_STALL).
  - count is registered, so the earliest response is the cycle after its grant (minimum latency 1).
- rdata_o = rand_rdata_i when rvalid_o and the head entry is a read; otherwise 0.
- Txn FIFO (depth MAX_OUTSTANDING):
  - push {we_i, addr_i, be_i} on gnt_o; pop head on rvalid_o.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo depth.
  - Push when full without a same-cycle pop is impossible by construction; assert it.
- gnt_stall counter:
  - increments each cycle req_i && !gnt_o; cleared on gnt_o or !req_i;
  - saturates at MAX_STALL, which forces grant if a slot is free.
  - If the slot is blocked, the counter holds at MAX_STALL.
- rsp_stall counter:
  - increments each cycle count > 0 && !rvalid_o; cleared on rvalid_o or count == 0;
  - saturates at MAX_STALL, which forces rvalid.
- MAX_STALL = 0: forcing terms are disabled and counters are held at 0.
- Stability check (OBI):
  - If req_i was high and not granted in cycle N, then in cycle N+1 req_i must be 1 and addr/we/be/wdata must equal the registered snapshot.
  - Any violation sets proto_err_o on the next edge; it stays set until reset.
- outstanding_o mirrors count, zero-extended.
- Embedded immediate assertions, under `FORMAL:
  - !(gnt_o && !req_i);
  - !(rvalid_o && count == 0);
  - count <= MAX_OUTSTANDING.

Decomposition:
- Package rvfi_obi_pkg:
  - typedef obi_txn_t {we, be[3:0], addr[31:0]};
  - localparam OBI_CNT_W = 3.
- Sub-module rvfi_obi_txn_fifo: parameterised depth, push/pop, count, head. This is the natural split; the stall counters and stability checker stay in the top.
- The wrapper instantiates rvfi_obi_mem_model twice (instr, data). It replaces the free gnt/rvalid regs and the no-grant-without-request assumes.

Test Plan:
- Single read: req_i = 1, addr 0x1A000080, rand_gnt = 1 at cycle 0 → gnt_o = 1 at cycle 0. Then rand_rvalid = 1, rdata 0xDEADBEEF at cycle 2 → rvalid_o = 1, rdata_o = 0xDEADBEEF; outstanding 0→1→0.
- Write: we_i = 1, be 4'b0011, granted at cycle 0, rand_rvalid = 1 and rand_rdata = 0x12345678 at cycle 1 → rvalid_o = 1, rdata_o = 0.
- Full window, MAX_OUTSTANDING = 2:
  - two grants with no responses; third req with rand_gnt = 1 → gnt_o = 0;
  - in the cycle rand_rvalid = 1, gnt_o = 1 and outstanding stays 2.
- Fairness, MAX_STALL = 4:
  - req_i held, rand_gnt = 0 → gnt_o = 0 for 4 cycles, forced to 1 on the 5th;
  - likewise rvalid_o forced on the 5th pending cycle with rand_rvalid = 0.
- Stability violation: req_i = 1 ungranted at 0x100, next cycle addr 0x104 → proto_err_o = 1 from the following edge, held until reset.
- Reset mid-op: 2 outstanding, assert reset asynchronously → gnt_o/rvalid_o/outstanding_o = 0 immediately. After release, rand_rvalid = 1 with req_i = 0 → rvalid_o stays 0.

Source files
------------

// File: rtl/rvfi_obi_pkg.sv
// rtl/rvfi_obi_pkg.sv - shared types for the OBI memory responder model
package rvfi_obi_pkg;

  // Width of the outstanding-transaction counter (covers depths up to 4)
  localparam int unsigned OBI_CNT_W = 3;

  // One granted transaction as remembered until its response
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
  } obi_txn_t;

endpackage

// File: rtl/rvfi_obi_txn_fifo.sv
// rtl/rvfi_obi_txn_fifo.sv - in-order queue of granted, not yet answered transactions
module rvfi_obi_txn_fifo
  import rvfi_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  obi_txn_t             din_i,
  output logic [OBI_CNT_W-1:0] count_o,
  output obi_txn_t             head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OBI_CNT_W-1:0] FULL_CNT = OBI_CNT_W'(DEPTH);

  obi_txn_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OBI_CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap at DEPTH, not at a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; a push into a full queue only happens alongside a pop,
  // so overwriting the head slot is safe because the head is consumed this cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

`ifdef FORMAL
  // Overflow is excluded by the grant logic upstream
  always_comb begin
    if (!reset) begin
      assert (!(push_i && !pop_i && count_q == FULL_CNT));
    end
  end
`endif

endmodule

// File: rtl/rvfi_obi_mem_model.sv
// rtl/rvfi_obi_mem_model.sv - protocol-legal OBI responder driven by free solver choices
module rvfi_obi_mem_model
  import rvfi_obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned MAX_STALL       = 4,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_i,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 rand_gnt_i,
  input  logic                 rand_rvalid_i,
  input  logic [DATA_W-1:0]    rand_rdata_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic [OBI_CNT_W-1:0] outstanding_o,
  output logic                 proto_err_o
);

  localparam int unsigned STALL_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(MAX_STALL);
  localparam logic [OBI_CNT_W-1:0] CNT_MAX   = OBI_CNT_W'(MAX_OUTSTANDING);
  localparam bit                   STALL_EN  = (MAX_STALL != 0);

  logic [OBI_CNT_W-1:0] count;
  obi_txn_t             head;
  obi_txn_t             cur_txn;
  logic                 slot_free;
  logic                 gnt_force;
  logic                 rsp_force;
  logic                 gnt;
  logic                 rvalid;
  logic                 violation;
  logic                 unused_head;

  logic [STALL_W-1:0]   gnt_stall_q, gnt_stall_d;
  logic [STALL_W-1:0]   rsp_stall_q, rsp_stall_d;
  logic                 pend_q, pend_d;
  obi_txn_t             snap_txn_q, snap_txn_d;
  logic [DATA_W-1:0]    snap_wdata_q, snap_wdata_d;
  logic                 proto_err_q, proto_err_d;

  assign cur_txn = '{we: we_i, be: be_i, addr: addr_i};

  // Only the head's direction matters for the response; address and strobes are kept for debug
  assign unused_head = ^{head.addr, head.be};

  // Handshake decisions; reset gates them directly so outputs drop asynchronously
  always_comb begin
    gnt_force = STALL_EN && (gnt_stall_q == STALL_MAX);
    rsp_force = STALL_EN && (rsp_stall_q == STALL_MAX);
    rvalid    = !reset && (count != '0) && (rand_rvalid_i || rsp_force);
    slot_free = (count < CNT_MAX) || rvalid;
    gnt       = !reset && req_i && slot_free && (rand_gnt_i || gnt_force);
  end

  rvfi_obi_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_txn_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (gnt),
    .pop_i   (rvalid),
    .din_i   (cur_txn),
    .count_o (count),
    .head_o  (head)
  );

  // Fairness counters: count withheld cycles, saturate to force the handshake
  always_comb begin
    gnt_stall_d = '0;
    rsp_stall_d = '0;
    if (STALL_EN) begin
      if (req_i && !gnt) begin
        gnt_stall_d = (gnt_stall_q == STALL_MAX) ? gnt_stall_q : gnt_stall_q + 1'b1;
      end
      if ((count != '0) && !rvalid) begin
        rsp_stall_d = (rsp_stall_q == STALL_MAX) ? rsp_stall_q : rsp_stall_q + 1'b1;
      end
    end
  end

  // Stability check: an ungranted request must be repeated unchanged next cycle
  always_comb begin
    violation    = pend_q && (!req_i || (cur_txn != snap_txn_q) || (wdata_i != snap_wdata_q));
    pend_d       = req_i && !gnt;
    snap_txn_d   = cur_txn;
    snap_wdata_d = wdata_i;
    proto_err_d  = proto_err_q || violation;
  end

  // State registers for stall counters, request snapshot and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_stall_q  <= '0;
      rsp_stall_q  <= '0;
      pend_q       <= 1'b0;
      snap_txn_q   <= '0;
      snap_wdata_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      gnt_stall_q  <= gnt_stall_d;
      rsp_stall_q  <= rsp_stall_d;
      pend_q       <= pend_d;
      snap_txn_q   <= snap_txn_d;
      snap_wdata_q <= snap_wdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign gnt_o         = gnt;
  assign rvalid_o      = rvalid;
  assign rdata_o       = (rvalid && !head.we) ? rand_rdata_i : '0;
  assign outstanding_o = count;
  assign proto_err_o   = proto_err_q;

`ifdef FORMAL
  // Guarantees this responder gives the core
  always_comb begin
    assert (!(gnt_o && !req_i));
    assert (!(rvalid_o && count == '0));
    assert (count <= CNT_MAX);
  end
`endif

endmodule

// File: tb/tb_rvfi_obi_mem_model.sv
// tb/tb_rvfi_obi_mem_model.sv - directed self-checking bench for the OBI responder model
module tb_rvfi_obi_mem_model;

  logic        clk;
  logic        reset;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rand_gnt_i;
  logic        rand_rvalid_i;
  logic [31:0] rand_rdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [2:0]  outstanding_o;
  logic        proto_err_o;

  int n_pass  = 0;
  int n_total = 0;
  bit exp_q[$];

  rvfi_obi_mem_model #(
    .MAX_OUTSTANDING (2),
    .MAX_STALL       (4),
    .DATA_W          (32)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .rand_gnt_i    (rand_gnt_i),
    .rand_rvalid_i (rand_rvalid_i),
    .rand_rdata_i  (rand_rdata_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .outstanding_o (outstanding_o),
    .proto_err_o   (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a grant now and record the transaction direction in the scoreboard
  task automatic expect_gnt(input string tag, input bit is_write);
    check(tag, 32'(gnt_o), 32'd1);
    if (gnt_o === 1'b1) exp_q.push_back(is_write);
  endtask

  // Expect a response now and compare it to the oldest scoreboard entry
  task automatic expect_rsp(input string tag, input logic [31:0] stim);
    bit w;
    check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      check({tag, "_rdata"}, rdata_o, w ? 32'd0 : stim);
    end
  endtask

  task automatic check_count(input string tag);
    check(tag, 32'(outstanding_o), 32'(exp_q.size()));
  endtask

  initial begin
    reset = 1'b1; req_i = 1'b1; addr_i = 32'h0; we_i = 1'b0; be_i = 4'hF; wdata_i = 32'h0;
    rand_gnt_i = 1'b1; rand_rvalid_i = 1'b1; rand_rdata_i = 32'hFFFF_FFFF;
    #2;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_outstanding", 32'(outstanding_o), 32'd0);
    check("rst_proto_err", 32'(proto_err_o), 32'd0);
    tick();
    req_i = 1'b0; rand_gnt_i = 1'b0; rand_rvalid_i = 1'b0;
    reset = 1'b0;
    tick();

    // Single read, response two cycles after grant
    req_i = 1'b1; addr_i = 32'h1A00_0080; we_i = 1'b0; be_i = 4'hF; rand_gnt_i = 1'b1;
    #1;
    expect_gnt("rd_gnt", 1'b0);
    check("rd_out0", 32'(outstanding_o), 32'd0);
    tick();
    req_i = 1'b0; rand_gnt_i = 1'b0;
    #1;
    check_count("rd_out1");
    check("rd_no_early_rvalid", 32'(rvalid_o), 32'd0);
    tick();
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'hDEAD_BEEF;
    #1;
    expect_rsp("rd", rand_rdata_i);
    tick();
    rand_rvalid_i = 1'b0;
    check_count("rd_out2");

    // Write: response carries zero data
    req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h1A00_0100; wdata_i = 32'hCAFE_0001;
    rand_gnt_i = 1'b1;
    #1;
    expect_gnt("wr_gnt", 1'b1);
    tick();
    req_i = 1'b0; we_i = 1'b0; be_i = 4'hF; rand_gnt_i = 1'b0;
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'h1234_5678;
    #1;
    expect_rsp("wr", rand_rdata_i);
    tick();
    rand_rvalid_i = 1'b0;
    check_count("wr_out");

    // Full window: two grants, third blocked until a response frees a slot
    req_i = 1'b1; addr_i = 32'h0000_2000; rand_gnt_i = 1'b1;
    #1;
    expect_gnt("full_g0", 1'b0);
    tick();
    addr_i = 32'h0000_2004;
    #1;
    expect_gnt("full_g1", 1'b0);
    tick();
    addr_i = 32'h0000_2008;
    #1;
    check("full_blocked", 32'(gnt_o), 32'd0);
    check_count("full_out2");
    tick();
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'hA5A5_0001;
    #1;
    expect_rsp("full_r0", rand_rdata_i);
    expect_gnt("full_g2", 1'b0);
    tick();
    req_i = 1'b0; rand_gnt_i = 1'b0;
    check_count("full_out_hold");
    rand_rdata_i = 32'hA5A5_0002;
    #1;
    expect_rsp("full_r1", rand_rdata_i);
    tick();
    rand_rdata_i = 32'hA5A5_0003;
    #1;
    expect_rsp("full_r2", rand_rdata_i);
    tick();
    rand_rvalid_i = 1'b0;
    check_count("full_drained");
    check("full_proto_ok", 32'(proto_err_o), 32'd0);

    // Fairness: grant forced on the fifth stalled cycle
    req_i = 1'b1; addr_i = 32'h0000_3000; rand_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fair_gnt_stall%0d", i), 32'(gnt_o), 32'd0);
      tick();
    end
    #1;
    expect_gnt("fair_gnt_forced", 1'b0);
    tick();
    req_i = 1'b0;
    rand_rdata_i = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("fair_rsp_stall%0d", i), 32'(rvalid_o), 32'd0);
      tick();
    end
    #1;
    expect_rsp("fair_rsp_forced", rand_rdata_i);
    tick();
    check_count("fair_out");
    check("fair_proto_ok", 32'(proto_err_o), 32'd0);

    // Stability violation: address changes while ungranted
    req_i = 1'b1; addr_i = 32'h0000_0100; rand_gnt_i = 1'b0;
    #1;
    check("stab_gnt0", 32'(gnt_o), 32'd0);
    tick();
    addr_i = 32'h0000_0104;
    #1;
    check("stab_err_not_yet", 32'(proto_err_o), 32'd0);
    tick();
    req_i = 1'b0;
    check("stab_err_set", 32'(proto_err_o), 32'd1);
    tick();
    tick();
    check("stab_err_sticky", 32'(proto_err_o), 32'd1);

    // Reset mid-operation with two outstanding transactions
    req_i = 1'b1; addr_i = 32'h0000_4000; rand_gnt_i = 1'b1;
    #1;
    expect_gnt("rst_g0", 1'b0);
    tick();
    addr_i = 32'h0000_4004;
    #1;
    expect_gnt("rst_g1", 1'b0);
    tick();
    req_i = 1'b0; rand_gnt_i = 1'b0;
    check_count("rst_pre_out2");
    #2;
    reset = 1'b1;
    req_i = 1'b1; rand_gnt_i = 1'b1;
    #1;
    check("rst_mid_gnt", 32'(gnt_o), 32'd0);
    check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_mid_out", 32'(outstanding_o), 32'd0);
    check("rst_mid_proto", 32'(proto_err_o), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0; req_i = 1'b0; rand_gnt_i = 1'b0; rand_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("post_rst_rvalid%0d", i), 32'(rvalid_o), 32'd0);
      tick();
    end
    check_count("post_rst_out");
    check("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
